// File: rtl/dm_lsu.sv
// dm_lsu: load/store unit with an internal single-port data RAM.
// Accepts one access per IDLE visit. A store finishes 1 cycle after acceptance
// (IDLE->WR). A load finishes 2 cycles after acceptance (IDLE->RD->RESP).
// Optional macro DM_MISALIGN_CHK_EN: misaligned half/word accesses fault
// (IDLE->RESP, no RAM access). Without it, low address bits are forced to
// alignment.
//
// Ports:
//   clk       clock, rising edge
//   reset     asynchronous active-low reset
//   req       access request, sampled in IDLE only
//   we        1 = store, 0 = load
//   size      00 byte, 01 half, 10/11 word
//   sign_ext  sign-extend sub-word loads
//   addr      byte address (wraps modulo RAM size)
//   wdata     store data, sub-word stores use the low bits
//   busy      access in progress
//   done      one-cycle completion pulse
//   rdata     extended load result, held until the next accepted load
//   misalign  alignment fault flag, valid with done
module dm_lsu #(
    parameter int unsigned DEPTH_WORDS = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic        misalign
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam int unsigned BW = AW + 2;

    typedef enum logic [1:0] {IDLE, RD, RESP, WR} state_t;

    state_t        state;
    state_t        state_next;
    logic          accept;
    logic          mis_in;

    logic [BW-1:0] addr_q;
    logic [1:0]    size_q;
    logic          sext_q;
    logic [31:0]   wdata_q;

    logic [31:0]   mem [DEPTH_WORDS];
    logic [31:0]   rd_word;
    logic [3:0]    be;
    logic [31:0]   wlanes;
    logic [31:0]   load_val;

    // Address bits above the RAM range are deliberately dropped.
    logic [31-BW:0] unused_addr;
    assign unused_addr = addr[31:BW];

`ifdef DM_MISALIGN_CHK_EN
    assign mis_in = ((size == 2'b01) && addr[0]) || (size[1] && (addr[1:0] != 2'b00));
`else
    assign mis_in = 1'b0;
`endif

    // Next-state logic.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    accept = 1'b1;
                    if (mis_in)  state_next = RESP;
                    else if (we) state_next = WR;
                    else         state_next = RD;
                end
            end
            RD:      state_next = RESP;
            RESP:    state_next = IDLE;
            WR:      state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // Request capture.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q  <= '0;
            size_q  <= 2'b00;
            sext_q  <= 1'b0;
            wdata_q <= '0;
        end else if (accept) begin
            addr_q  <= addr[BW-1:0];
            size_q  <= size;
            sext_q  <= sign_ext;
            wdata_q <= wdata;
        end
    end

    // Store byte enables and lane-replicated write data.
    always_comb begin
        be     = 4'hF;
        wlanes = wdata_q;
        case (size_q)
            2'b00: begin
                be     = 4'b0001 << addr_q[1:0];
                wlanes = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                be     = addr_q[1] ? 4'b1100 : 4'b0011;
                wlanes = {2{wdata_q[15:0]}};
            end
            default: begin
                be     = 4'hF;
                wlanes = wdata_q;
            end
        endcase
    end

    // RAM: read address presented at acceptance so data is ready during RD.
    always_ff @(posedge clk) begin
        if (state == IDLE) rd_word <= mem[addr[BW-1:2]];
        if (state == WR) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[addr_q[BW-1:2]][8*b +: 8] <= wlanes[8*b +: 8];
            end
        end
    end

    // Little-endian lane select and extension of the RAM word.
    always_comb begin
        logic [7:0]  lb;
        logic [15:0] lh;
        lb       = 8'h00;
        lh       = addr_q[1] ? rd_word[31:16] : rd_word[15:0];
        load_val = rd_word;
        case (addr_q[1:0])
            2'd0:    lb = rd_word[7:0];
            2'd1:    lb = rd_word[15:8];
            2'd2:    lb = rd_word[23:16];
            default: lb = rd_word[31:24];
        endcase
        case (size_q)
            2'b00:   load_val = {{24{sext_q & lb[7]}}, lb};
            2'b01:   load_val = {{16{sext_q & lh[15]}}, lh};
            default: load_val = rd_word;
        endcase
    end

    // Registered outputs, decoded from the next state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy  <= 1'b0;
            done  <= 1'b0;
            rdata <= '0;
        end else begin
            busy <= (state_next != IDLE);
            done <= (state_next == RESP) || (state_next == WR);
            if (state == RD)                   rdata <= load_val;
            else if (accept && mis_in && !we)  rdata <= '0;
        end
    end

`ifdef DM_MISALIGN_CHK_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) misalign <= 1'b0;
        else        misalign <= accept && mis_in;
    end
`else
    assign misalign = 1'b0;
`endif

endmodule

// File: tb/tb_dm_lsu.sv
// tb_dm_lsu: directed vector table plus hand sequences for req-hold,
// mid-store reset and misalignment behaviour of dm_lsu.
module tb_dm_lsu;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [1:0]  size = 2'b00;
    logic        sign_ext = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        busy;
    logic        done;
    logic [31:0] rdata;
    logic        misalign;

    int total = 0;
    int bad = 0;

    dm_lsu #(.DEPTH_WORDS(1024)) dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .size(size),
        .sign_ext(sign_ext), .addr(addr), .wdata(wdata),
        .busy(busy), .done(done), .rdata(rdata), .misalign(misalign)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        sext;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        chk_rd;
        logic [31:0] exp_rd;
        int          exp_lat;
        logic        exp_mis;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic vec_t st(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
        vec_t v;
        v = '{we: 1'b1, size: sz, sext: 1'b0, addr: a, wdata: d,
              chk_rd: 1'b0, exp_rd: 32'h0, exp_lat: 1, exp_mis: 1'b0};
        return v;
    endfunction

    function automatic vec_t ld(input logic [1:0] sz, input logic sx, input logic [31:0] a, input logic [31:0] e);
        vec_t v;
        v = '{we: 1'b0, size: sz, sext: sx, addr: a, wdata: 32'h0,
              chk_rd: 1'b1, exp_rd: e, exp_lat: 2, exp_mis: 1'b0};
        return v;
    endfunction

    // One access from IDLE; latency counts cycles from acceptance to done.
    task automatic run_acc(input logic w, input logic [1:0] sz, input logic sx,
                           input logic [31:0] a, input logic [31:0] d,
                           output logic [31:0] rd, output int lat,
                           output logic mis, output logic idle_busy);
        @(negedge clk);
        req = 1'b1; we = w; size = sz; sign_ext = sx; addr = a; wdata = d;
        @(negedge clk);
        req = 1'b0;
        lat = 1;
        while (done !== 1'b1 && lat < 5) begin
            @(negedge clk);
            lat++;
        end
        rd  = rdata;
        mis = misalign;
        @(negedge clk);
        idle_busy = busy;
    endtask

    initial begin
        logic [31:0] rd;
        int          lat;
        logic        mis;
        logic        ib;

        // Reset state.
        #2 reset = 1'b0;
        #1;
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_mis", 32'(misalign), 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        vecs.push_back(st(2'b10, 32'h10, 32'hDEADBEEF));
        vecs.push_back(ld(2'b10, 1'b0, 32'h10, 32'hDEADBEEF));
        vecs.push_back(st(2'b00, 32'h13, 32'h1234565A));
        vecs.push_back(ld(2'b00, 1'b1, 32'h13, 32'h0000005A));
        vecs.push_back(ld(2'b00, 1'b1, 32'h12, 32'hFFFFFFAD));
        vecs.push_back(ld(2'b00, 1'b0, 32'h12, 32'h000000AD));
        vecs.push_back(ld(2'b10, 1'b0, 32'h10, 32'h5AADBEEF));
        vecs.push_back(st(2'b10, 32'h20, 32'h76543210));
        vecs.push_back(st(2'b01, 32'h22, 32'hABCD8001));
        vecs.push_back(ld(2'b01, 1'b1, 32'h22, 32'hFFFF8001));
        vecs.push_back(ld(2'b01, 1'b0, 32'h22, 32'h00008001));
        vecs.push_back(ld(2'b10, 1'b0, 32'h20, 32'h80013210));
        vecs.push_back(ld(2'b00, 1'b0, 32'h21, 32'h00000032));
        vecs.push_back(ld(2'b01, 1'b1, 32'h20, 32'h00003210));
        vecs.push_back(ld(2'b11, 1'b1, 32'h20, 32'h80013210));
        vecs.push_back(ld(2'b10, 1'b0, 32'h1010, 32'h5AADBEEF));
        vecs.push_back(st(2'b10, 32'hFFFFF030, 32'hCAFEF00D));
        vecs.push_back(ld(2'b10, 1'b0, 32'h30, 32'hCAFEF00D));
        vecs.push_back(ld(2'b00, 1'b1, 32'h31, 32'hFFFFFFF0));
        vecs.push_back(ld(2'b00, 1'b0, 32'h33, 32'h000000CA));
        vecs.push_back(st(2'b10, 32'h40, 32'h11111111));

        foreach (vecs[i]) begin
            run_acc(vecs[i].we, vecs[i].size, vecs[i].sext, vecs[i].addr, vecs[i].wdata,
                    rd, lat, mis, ib);
            check($sformatf("v%0d_lat", i), 32'(lat), 32'(vecs[i].exp_lat));
            check($sformatf("v%0d_mis", i), 32'(mis), 32'(vecs[i].exp_mis));
            check($sformatf("v%0d_idle", i), 32'(ib), 32'h0);
            if (vecs[i].chk_rd) check($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rd);
        end

        // req held high: one access per IDLE visit, mid-access requests ignored.
        @(negedge clk);
        req = 1'b1; we = 1'b0; size = 2'b10; sign_ext = 1'b0; addr = 32'h10;
        @(negedge clk);
        check("hold_rd_busy", 32'(busy), 32'h1);
        check("hold_rd_done", 32'(done), 32'h0);
        addr = 32'h20;
        @(negedge clk);
        check("hold_resp_busy", 32'(busy), 32'h1);
        check("hold_resp_done", 32'(done), 32'h1);
        check("hold_resp_rdata", rdata, 32'h5AADBEEF);
        @(negedge clk);
        check("hold_idle_busy", 32'(busy), 32'h0);
        check("hold_idle_done", 32'(done), 32'h0);
        @(negedge clk);
        check("hold_re_busy", 32'(busy), 32'h1);
        check("hold_re_done", 32'(done), 32'h0);
        req = 1'b0;
        @(negedge clk);
        check("hold2_done", 32'(done), 32'h1);
        check("hold2_rdata", rdata, 32'h80013210);
        @(negedge clk);
        check("hold2_idle", 32'(busy), 32'h0);

        // Reset during WR aborts the store.
        @(negedge clk);
        req = 1'b1; we = 1'b1; size = 2'b10; addr = 32'h40; wdata = 32'h22222222;
        @(negedge clk);
        req = 1'b0;
        check("wr_done_before_rst", 32'(done), 32'h1);
        #1 reset = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'h0);
        check("midrst_done", 32'(done), 32'h0);
        check("midrst_rdata", rdata, 32'h0);
        check("midrst_mis", 32'(misalign), 32'h0);
        @(negedge clk);
        reset = 1'b1;
        run_acc(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, rd, lat, mis, ib);
        check("post_rst_lat", 32'(lat), 32'd2);
        check("post_rst_rdata", rd, 32'h11111111);

`ifdef DM_MISALIGN_CHK_EN
        run_acc(1'b0, 2'b10, 1'b0, 32'h41, 32'h0, rd, lat, mis, ib);
        check("mis_lw_lat", 32'(lat), 32'd1);
        check("mis_lw_flag", 32'(mis), 32'h1);
        check("mis_lw_rdata", rd, 32'h0);
        run_acc(1'b1, 2'b10, 1'b0, 32'h42, 32'h99999999, rd, lat, mis, ib);
        check("mis_sw_lat", 32'(lat), 32'd1);
        check("mis_sw_flag", 32'(mis), 32'h1);
        run_acc(1'b0, 2'b01, 1'b1, 32'h23, 32'h0, rd, lat, mis, ib);
        check("mis_lh_flag", 32'(mis), 32'h1);
        check("mis_lh_rdata", rd, 32'h0);
        run_acc(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, rd, lat, mis, ib);
        check("mis_mem_kept", rd, 32'h11111111);
        check("mis_clear", 32'(mis), 32'h0);
`else
        run_acc(1'b0, 2'b10, 1'b0, 32'h41, 32'h0, rd, lat, mis, ib);
        check("una_lw_lat", 32'(lat), 32'd2);
        check("una_lw_rdata", rd, 32'h11111111);
        check("una_lw_mis", 32'(mis), 32'h0);
        run_acc(1'b0, 2'b01, 1'b1, 32'h23, 32'h0, rd, lat, mis, ib);
        check("una_lh_rdata", rd, 32'hFFFF8001);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dm_lsu.md
DM_LSU -- requirements
Module: dm_lsu

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 1024, giving the number of 32-bit words in the internal data RAM (power of two).
REQ-002 The block SHALL have port clk  input  1  the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL have port req  input  1  access request, sampled only in IDLE.
REQ-005 The block SHALL have port we  input  1  1 = store, 0 = load; sampled with req.
REQ-006 The block SHALL have port size  input  2  access size: 00 byte, 01 halfword, 10 word, 11 treated as word.
REQ-007 The block SHALL have port sign_ext  input  1  1 = sign-extend sub-word loads (lb/lh), 0 = zero-extend (lbu/lhu).
REQ-008 The block SHALL have port addr  input  32  byte address, taken from the ALU result.
REQ-009 The block SHALL have port wdata  input  32  store data from GPR RD2; sub-word stores use the low bits.
REQ-010 The block SHALL have port busy  output  1  high while an accepted access is in progress; the CPU stalls PC/GPR writes while high.
REQ-011 The block SHALL have port done  output  1  single-cycle pulse when an access completes.
REQ-012 The block SHALL have port rdata  output  32  extended load result, valid in the done cycle and held until the next accepted load.
REQ-013 The block SHALL have port misalign  output  1  alignment fault flag, valid in the done cycle.

Function
REQ-014 The FSM SHALL have states IDLE, RD, RESP, WR; it leaves IDLE only when req=1.
REQ-015 A request SHALL be accepted in IDLE: addr, size, sign_ext, we and wdata are registered; req while busy=1 SHALL be ignored.
REQ-016 A store SHALL go IDLE->WR->IDLE: the RAM word at addr[log2(DEPTH_WORDS)+1:2] is written in the WR cycle with byte enables; done=1 in WR; latency 1 cycle after acceptance.
REQ-017 Byte enables SHALL be: byte -> lane addr[1:0] written with wdata[7:0]; half -> lanes {addr[1],0} and {addr[1],1} written with wdata[15:0]; word -> all lanes with wdata; unselected bytes unchanged.
REQ-018 A load SHALL go IDLE->RD->RESP->IDLE: synchronous RAM read issued in RD, data formatted and registered into rdata in RESP with done=1; latency 2 cycles after acceptance.
REQ-019 Lane selection for loads SHALL be little-endian: byte lane = addr[1:0], halfword lane = addr[1]; result extended to 32 bits per sign_ext; word loads ignore sign_ext.
REQ-020 Address bits above log2(DEPTH_WORDS)+1 SHALL be ignored (address wraps modulo RAM size).
REQ-021 busy SHALL be 1 in RD, RESP and WR and 0 in IDLE; done SHALL be 0 in every state other than RESP and WR.
REQ-022 A new req presented in the same cycle as done SHALL be ignored; the earliest re-acceptance is the cycle after done.

Reset
REQ-023 While reset=0, the FSM SHALL be in IDLE with busy=0, done=0, rdata=0, misalign=0, asynchronously.
REQ-024 Reset asserted mid-access SHALL abort the access: a store in WR at the reset edge SHALL NOT be written; RAM contents are not cleared by reset.

Configuration
REQ-025 With macro DM_MISALIGN_CHK_EN defined, a halfword with addr[0]=1 or a word with addr[1:0]!=0 SHALL perform no RAM access, go IDLE->RESP->IDLE, and assert done=1, misalign=1, rdata=0 (load) one cycle after acceptance.
REQ-026 Without DM_MISALIGN_CHK_EN, misalign SHALL be tied 0, the word access SHALL use addr with bits [1:0] forced to 0, and the halfword access SHALL use addr with bit [0] forced to 0.

Verification
REQ-027 Store word 0xDEADBEEF at 0x10, then load word at 0x10 -> done one cycle after store acceptance; rdata=0xDEADBEEF two cycles after load acceptance.
REQ-028 After REQ-027, store byte 0x5A at 0x13, then lb 0x13 -> rdata=0x0000005A; lb 0x12 -> 0xFFFFFFAD; lbu 0x12 -> 0x000000AD; lw 0x10 -> 0x5AADBEEF.
REQ-029 Store half 0x8001 at 0x22, then lh 0x22 -> 0xFFFF8001 and lhu 0x22 -> 0x00008001; word at 0x20 has its low half unchanged.
REQ-030 Hold req=1 continuously through a load -> exactly one access per IDLE visit; requests during RD/RESP are ignored; busy pattern is 1,1,0.
REQ-031 Assert reset=0 in the WR cycle of a store to 0x40 holding 0x11111111, new data 0x22222222 -> outputs zero immediately; subsequent lw 0x40 returns 0x11111111.
REQ-032 With DM_MISALIGN_CHK_EN defined, lw at 0x41 -> done and misalign=1 one cycle after acceptance, rdata=0; sw at 0x42 leaves memory unchanged; without the macro, lw at 0x41 returns the word at 0x40.
